// File: rtl/secuenciador_registros_rtc.sv
// Sequencer for the 9-register VGA bank: periodically reads all nine RTC registers over the
// PicoBlaze/RTC handshake, and hands one register group to the edit counters with a write-back when editing ends.
module secuenciador_registros_rtc #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scan_tick,
    input  logic       edit_en,
    input  logic [1:0] edit_group,
    input  logic       ack,
    output logic       rd_req,
    output logic       wr_req,
    output logic [7:0] addr,
    output logic [3:0] wr_sel,
    output logic [8:0] cs_reg,
    output logic [8:0] hold_reg,
    output logic       busy,
    output logic       err_timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_REQ,
        S_RD_WAIT,
        S_LOAD,
        S_EDIT,
        S_WR_REQ,
        S_WR_WAIT
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    function automatic logic [7:0] map_addr(input logic [3:0] i);
        case (i)
            4'd0:    map_addr = 8'h21;
            4'd1:    map_addr = 8'h22;
            4'd2:    map_addr = 8'h23;
            4'd3:    map_addr = 8'h24;
            4'd4:    map_addr = 8'h25;
            4'd5:    map_addr = 8'h26;
            4'd6:    map_addr = 8'h41;
            4'd7:    map_addr = 8'h42;
            4'd8:    map_addr = 8'h43;
            default: map_addr = 8'h00;
        endcase
    endfunction

    function automatic logic [8:0] group_mask(input logic [1:0] g);
        case (g)
            2'd0:    group_mask = 9'h007;
            2'd1:    group_mask = 9'h038;
            2'd2:    group_mask = 9'h1C0;
            default: group_mask = 9'h000;
        endcase
    endfunction

    state_t     st_q, st_d;
    logic [3:0] idx_q, idx_d;
    logic [3:0] widx_q, widx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       rescan_q, rescan_d;

    logic       rd_req_q, rd_req_d;
    logic       wr_req_q, wr_req_d;
    logic [7:0] addr_q, addr_d;
    logic [3:0] wr_sel_q, wr_sel_d;
    logic [8:0] cs_q, cs_d;
    logic [8:0] hold_q, hold_d;
    logic       busy_q, busy_d;

    logic       edit_ok_s;
    logic       timeout_s;
    logic       wlast_s;
    logic [3:0] wbase_s;
    state_t     adv_st_s;
    logic [3:0] adv_idx_s;
    logic       adv_rescan_s;

    assign edit_ok_s = edit_en && (edit_group != 2'd3);
    assign timeout_s = (cnt_q == TO_LAST);
    assign wlast_s   = (widx_q == 4'd2) || (widx_q == 4'd5) || (widx_q == 4'd8);
    assign wbase_s   = {2'b00, edit_group} * 4'd3;

    // Decision taken at the end of every read transaction (after LOAD or a timeout);
    // the forced re-scan after a write-back is never aborted by editing.
    always_comb begin
        adv_st_s     = S_RD_REQ;
        adv_idx_s    = idx_q + 4'd1;
        adv_rescan_s = rescan_q;
        if (edit_ok_s && !rescan_q) begin
            adv_st_s  = S_EDIT;
            adv_idx_s = 4'd0;
        end else if (idx_q == 4'd8) begin
            adv_st_s     = S_IDLE;
            adv_idx_s    = 4'd0;
            adv_rescan_s = 1'b0;
        end else begin
            adv_st_s = S_RD_REQ;
        end
    end

    // Next-state logic of the sequencer.
    always_comb begin
        st_d     = st_q;
        idx_d    = idx_q;
        widx_d   = widx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rescan_d = rescan_q;
        case (st_q)
            S_IDLE: begin
                if (edit_ok_s) begin
                    st_d = S_EDIT;
                end else if (scan_tick) begin
                    st_d     = S_RD_REQ;
                    idx_d    = 4'd0;
                    err_d    = 1'b0;
                    rescan_d = 1'b0;
                end else begin
                    st_d = S_IDLE;
                end
            end
            S_RD_REQ: begin
                st_d  = S_RD_WAIT;
                cnt_d = 8'd0;
            end
            S_RD_WAIT: begin
                // Timeout has priority so an ack landing on the abandon cycle is ignored.
                if (timeout_s) begin
                    err_d    = 1'b1;
                    st_d     = adv_st_s;
                    idx_d    = adv_idx_s;
                    rescan_d = adv_rescan_s;
                end else if (ack) begin
                    st_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_LOAD: begin
                st_d     = adv_st_s;
                idx_d    = adv_idx_s;
                rescan_d = adv_rescan_s;
            end
            S_EDIT: begin
                if (edit_en) begin
                    st_d = S_EDIT;
                end else if (edit_group != 2'd3) begin
                    st_d   = S_WR_REQ;
                    widx_d = wbase_s;
                end else begin
                    st_d = S_IDLE;
                end
            end
            S_WR_REQ: begin
                st_d  = S_WR_WAIT;
                cnt_d = 8'd0;
            end
            S_WR_WAIT: begin
                if (timeout_s || ack) begin
                    if (timeout_s) begin
                        err_d = 1'b1;
                    end else begin
                        err_d = err_q;
                    end
                    if (wlast_s) begin
                        st_d     = S_RD_REQ;
                        idx_d    = 4'd0;
                        rescan_d = 1'b1;
                    end else begin
                        st_d   = S_WR_REQ;
                        widx_d = widx_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                st_d  = S_IDLE;
                idx_d = 4'd0;
            end
        endcase
    end

    // Output decode from the next state so every output is a plain register.
    always_comb begin
        rd_req_d = (st_d == S_RD_WAIT);
        wr_req_d = (st_d == S_WR_WAIT);
        addr_d   = 8'h00;
        wr_sel_d = 4'd0;
        cs_d     = 9'h000;
        hold_d   = 9'h1FF;
        busy_d   = 1'b1;
        case (st_d)
            S_IDLE: begin
                busy_d = 1'b0;
            end
            S_RD_REQ, S_RD_WAIT: begin
                addr_d = map_addr(idx_d);
            end
            S_LOAD: begin
                addr_d = map_addr(idx_d);
                cs_d   = 9'h001 << idx_d;
                hold_d = ~(9'h001 << idx_d);
            end
            S_EDIT: begin
                busy_d = 1'b0;
                hold_d = ~group_mask(edit_group);
            end
            S_WR_REQ, S_WR_WAIT: begin
                addr_d   = map_addr(widx_d);
                wr_sel_d = widx_d;
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q     <= S_IDLE;
            idx_q    <= 4'd0;
            widx_q   <= 4'd0;
            cnt_q    <= 8'd0;
            err_q    <= 1'b0;
            rescan_q <= 1'b0;
            rd_req_q <= 1'b0;
            wr_req_q <= 1'b0;
            addr_q   <= 8'h00;
            wr_sel_q <= 4'd0;
            cs_q     <= 9'h000;
            hold_q   <= 9'h1FF;
            busy_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            idx_q    <= idx_d;
            widx_q   <= widx_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rescan_q <= rescan_d;
            rd_req_q <= rd_req_d;
            wr_req_q <= wr_req_d;
            addr_q   <= addr_d;
            wr_sel_q <= wr_sel_d;
            cs_q     <= cs_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
        end
    end

    assign rd_req      = rd_req_q;
    assign wr_req      = wr_req_q;
    assign addr        = addr_q;
    assign wr_sel      = wr_sel_q;
    assign cs_reg      = cs_q;
    assign hold_reg    = hold_q;
    assign busy        = busy_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_secuenciador_registros_rtc.sv
// Scoreboard bench for secuenciador_registros_rtc: a bus responder, a transaction monitor
// and a model of the 9-register bank, with expected transactions queued as stimulus is driven.
module tb_secuenciador_registros_rtc;

    typedef struct packed {
        logic       wr;
        logic [7:0] a;
        logic [3:0] s;
        logic [7:0] len;
    } txn_t;

    localparam logic [7:0] MAP [9] = '{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h41, 8'h42, 8'h43};

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scan_tick = 1'b0;
    logic       edit_en = 1'b0;
    logic [1:0] edit_group = 2'd0;
    logic       ack = 1'b0;
    logic       rd_req, wr_req, busy, err_timeout;
    logic [7:0] addr;
    logic [3:0] wr_sel;
    logic [8:0] cs_reg, hold_reg;

    logic [7:0] data_bus = 8'h00;
    logic [7:0] data_base = 8'h00;
    logic [7:0] noack_addr = 8'h00;
    logic       ack_en = 1'b1;
    logic [7:0] bank [9] = '{default: 8'h00};

    txn_t exp_q[$];
    txn_t obs_q[$];
    int   obs_rd = 0;
    int   cs_count = 0;
    int   onehot_err = 0;
    int   compared = 0;
    int   mismatched = 0;

    secuenciador_registros_rtc #(.TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_tick  (scan_tick),
        .edit_en    (edit_en),
        .edit_group (edit_group),
        .ack        (ack),
        .rd_req     (rd_req),
        .wr_req     (wr_req),
        .addr       (addr),
        .wr_sel     (wr_sel),
        .cs_reg     (cs_reg),
        .hold_reg   (hold_reg),
        .busy       (busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    function automatic int addr_idx(input logic [7:0] a);
        if (a >= 8'h41) return int'(a - 8'h41) + 6;
        else return int'(a - 8'h21);
    endfunction

    function automatic txn_t mk(input logic wr, input logic [7:0] a, input logic [3:0] s, input logic [7:0] len);
        txn_t t;
        t.wr = wr; t.a = a; t.s = s; t.len = len;
        return t;
    endfunction

    // RTC bus responder: one-cycle ack the cycle after a request is seen, read data = base + index.
    always @(negedge clk) begin
        if (ack) begin
            ack = 1'b0;
        end else if (ack_en && rd_req && addr != noack_addr) begin
            ack = 1'b1;
            data_bus = data_base + 8'(addr_idx(addr));
        end else if (ack_en && wr_req) begin
            ack = 1'b1;
        end
    end

    // Transaction monitor: records each request pulse with its length, counts cs pulses.
    logic rd_prev = 1'b0, wr_prev = 1'b0;
    txn_t cur_rd, cur_wr;
    always @(negedge clk) begin
        if (rd_req) begin
            if (!rd_prev) cur_rd = mk(1'b0, addr, 4'd0, 8'd1);
            else cur_rd.len = cur_rd.len + 8'd1;
        end else if (rd_prev) obs_q.push_back(cur_rd);
        if (wr_req) begin
            if (!wr_prev) cur_wr = mk(1'b1, addr, wr_sel, 8'd1);
            else cur_wr.len = cur_wr.len + 8'd1;
        end else if (wr_prev) obs_q.push_back(cur_wr);
        rd_prev = rd_req;
        wr_prev = wr_req;
        if (cs_reg != 9'h000) cs_count++;
        if ($countones(cs_reg) > 1) onehot_err++;
    end

    // Bank model: hold=0 loads bus data when cs=1, else the edit-counter value A0+index.
    always @(posedge clk) begin
        for (int i = 0; i < 9; i++)
            if (!hold_reg[i]) bank[i] <= cs_reg[i] ? data_bus : (8'hA0 + 8'(i));
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        compared++; if (hold_reg !== 9'h1FF) begin mismatched++; $display("FAIL rst_hold: got %h want 1ff", hold_reg); end
        compared++; if (cs_reg !== 9'h000) begin mismatched++; $display("FAIL rst_cs: got %h want 000", cs_reg); end
        compared++; if ({rd_req, wr_req, busy, err_timeout} !== 4'b0000) begin mismatched++; $display("FAIL rst_flags: got %b want 0000", {rd_req, wr_req, busy, err_timeout}); end
        compared++; if ({addr, wr_sel} !== 12'h000) begin mismatched++; $display("FAIL rst_addr: got %h/%h want 00/0", addr, wr_sel); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        compared++; if (hold_reg !== 9'h1FF || cs_reg !== 9'h000 || rd_req !== 1'b0 || err_timeout !== 1'b0) begin
            mismatched++; $display("FAIL rst_release: hold %h cs %h rd %b err %b want 1ff 000 0 0", hold_reg, cs_reg, rd_req, err_timeout);
        end
    endtask

    task automatic test_scan();
        int n, cs0;
        txn_t e, o;
        obs_rd = obs_q.size(); data_base = 8'h10; cs0 = cs_count;
        for (int i = 0; i < 9; i++) exp_q.push_back(mk(1'b0, MAP[i], 4'd0, 8'd1));
        scan_tick = 1'b1; @(negedge clk); scan_tick = 1'b0; n = 0;
        compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL scan_busy_rise: got %b want 1", busy); end
        while (busy && n < 300) begin
            @(negedge clk); n++;
            scan_tick = (n == 10);
        end
        scan_tick = 1'b0;
        compared++; if (n != 27) begin mismatched++; $display("FAIL scan_duration: got %0d want 27", n); end
        repeat (5) @(negedge clk);
        compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL scan_dropped_tick: busy %b want 0", busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); compared++;
            if (obs_rd >= obs_q.size()) begin mismatched++; $display("FAIL scan_txn: got none want %h", e); end
            else begin o = obs_q[obs_rd]; obs_rd++; if (o !== e) begin mismatched++; $display("FAIL scan_txn: got %h want %h", o, e); end end
        end
        compared++; if (obs_rd != obs_q.size()) begin mismatched++; $display("FAIL scan_extra: got %0d want %0d", obs_q.size(), obs_rd); end
        compared++; if (cs_count - cs0 != 9 || onehot_err != 0) begin mismatched++; $display("FAIL scan_cs: pulses %0d onehot_err %0d want 9 0", cs_count - cs0, onehot_err); end
        for (int i = 0; i < 9; i++) begin
            compared++; if (bank[i] !== 8'h10 + 8'(i)) begin mismatched++; $display("FAIL scan_bank%0d: got %h want %h", i, bank[i], 8'h10 + 8'(i)); end
        end
    endtask

    task automatic test_timeout();
        int n;
        txn_t e, o;
        obs_rd = obs_q.size(); data_base = 8'h30; noack_addr = 8'h24;
        for (int i = 0; i < 9; i++) exp_q.push_back(mk(1'b0, MAP[i], 4'd0, (i == 3) ? 8'd8 : 8'd1));
        scan_tick = 1'b1; @(negedge clk); scan_tick = 1'b0; n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        compared++; if (n != 33) begin mismatched++; $display("FAIL to_duration: got %0d want 33", n); end
        compared++; if (err_timeout !== 1'b1) begin mismatched++; $display("FAIL to_err_set: got %b want 1", err_timeout); end
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); compared++;
            if (obs_rd >= obs_q.size()) begin mismatched++; $display("FAIL to_txn: got none want %h", e); end
            else begin o = obs_q[obs_rd]; obs_rd++; if (o !== e) begin mismatched++; $display("FAIL to_txn: got %h want %h", o, e); end end
        end
        for (int i = 0; i < 9; i++) begin
            compared++;
            if (bank[i] !== ((i == 3) ? 8'h13 : 8'h30 + 8'(i))) begin mismatched++; $display("FAIL to_bank%0d: got %h", i, bank[i]); end
        end
        noack_addr = 8'h00;
        scan_tick = 1'b1; @(negedge clk); scan_tick = 1'b0;
        compared++; if (err_timeout !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL to_err_clear: err %b busy %b want 0 1", err_timeout, busy); end
        n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        repeat (2) @(negedge clk);
        obs_rd = obs_q.size();
    endtask

    task automatic test_edit_abort();
        int n;
        txn_t e, o;
        obs_rd = obs_q.size(); data_base = 8'h50;
        for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b0, MAP[i], 4'd0, 8'd1));
        scan_tick = 1'b1; @(negedge clk); scan_tick = 1'b0; n = 0;
        while (!(rd_req && addr == 8'h25) && n < 100) begin @(negedge clk); n++; end
        edit_en = 1'b1; edit_group = 2'd2; n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        compared++; if (hold_reg !== 9'h03F || cs_reg !== 9'h000 || busy !== 1'b0) begin
            mismatched++; $display("FAIL edit_hold: hold %h cs %h busy %b want 03f 000 0", hold_reg, cs_reg, busy);
        end
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); compared++;
            if (obs_rd >= obs_q.size()) begin mismatched++; $display("FAIL edit_rd_txn: got none want %h", e); end
            else begin o = obs_q[obs_rd]; obs_rd++; if (o !== e) begin mismatched++; $display("FAIL edit_rd_txn: got %h want %h", o, e); end end
        end
        compared++; if (obs_rd != obs_q.size()) begin mismatched++; $display("FAIL edit_abort_extra: got %0d want %0d", obs_q.size(), obs_rd); end
        for (int i = 0; i < 9; i++) begin
            compared++;
            if (bank[i] !== ((i < 5) ? 8'h50 + 8'(i) : (i == 5) ? 8'h35 : 8'hA0 + 8'(i))) begin mismatched++; $display("FAIL edit_bank%0d: got %h", i, bank[i]); end
        end
        data_base = 8'h70;
        for (int i = 6; i < 9; i++) exp_q.push_back(mk(1'b1, MAP[i], 4'(i), 8'd1));
        for (int i = 0; i < 9; i++) exp_q.push_back(mk(1'b0, MAP[i], 4'd0, 8'd1));
        edit_en = 1'b0; n = 0;
        while (!busy && n < 10) begin @(negedge clk); n++; end
        n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); compared++;
            if (obs_rd >= obs_q.size()) begin mismatched++; $display("FAIL wb_txn: got none want %h", e); end
            else begin o = obs_q[obs_rd]; obs_rd++; if (o !== e) begin mismatched++; $display("FAIL wb_txn: got %h want %h", o, e); end end
        end
        for (int i = 0; i < 9; i++) begin
            compared++; if (bank[i] !== 8'h70 + 8'(i)) begin mismatched++; $display("FAIL wb_bank%0d: got %h want %h", i, bank[i], 8'h70 + 8'(i)); end
        end
    endtask

    task automatic test_group3();
        int n;
        txn_t e, o;
        edit_en = 1'b1; edit_group = 2'd3;
        repeat (3) @(negedge clk);
        compared++; if (busy !== 1'b0 || hold_reg !== 9'h1FF) begin mismatched++; $display("FAIL g3_idle: busy %b hold %h want 0 1ff", busy, hold_reg); end
        obs_rd = obs_q.size(); data_base = 8'h90;
        for (int i = 0; i < 9; i++) exp_q.push_back(mk(1'b0, MAP[i], 4'd0, 8'd1));
        scan_tick = 1'b1; @(negedge clk); scan_tick = 1'b0; n = 0;
        while (busy && n < 300) begin @(negedge clk); n++; end
        compared++; if (n != 27) begin mismatched++; $display("FAIL g3_duration: got %0d want 27", n); end
        repeat (2) @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); compared++;
            if (obs_rd >= obs_q.size()) begin mismatched++; $display("FAIL g3_txn: got none want %h", e); end
            else begin o = obs_q[obs_rd]; obs_rd++; if (o !== e) begin mismatched++; $display("FAIL g3_txn: got %h want %h", o, e); end end
        end
        for (int i = 0; i < 9; i++) begin
            compared++; if (bank[i] !== 8'h90 + 8'(i)) begin mismatched++; $display("FAIL g3_bank%0d: got %h want %h", i, bank[i], 8'h90 + 8'(i)); end
        end
        edit_en = 1'b0; edit_group = 2'd0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int n, cs0, nobs;
        ack_en = 1'b0;
        scan_tick = 1'b1; @(negedge clk); scan_tick = 1'b0; n = 0;
        while (!rd_req && n < 20) begin @(negedge clk); n++; end
        compared++; if (rd_req !== 1'b1) begin mismatched++; $display("FAIL mid_wait: rd_req %b want 1", rd_req); end
        #2 reset = 1'b0;
        #1;
        compared++; if (rd_req !== 1'b0 || hold_reg !== 9'h1FF || busy !== 1'b0 || cs_reg !== 9'h000) begin
            mismatched++; $display("FAIL mid_reset: rd %b hold %h busy %b cs %h want 0 1ff 0 000", rd_req, hold_reg, busy, cs_reg);
        end
        @(negedge clk); reset = 1'b1; ack_en = 1'b1;
        @(negedge clk);
        cs0 = cs_count; nobs = obs_q.size();
        repeat (40) @(negedge clk);
        compared++; if (cs_count != cs0 || obs_q.size() != nobs || busy !== 1'b0) begin
            mismatched++; $display("FAIL mid_quiet: cs %0d txns %0d busy %b want 0 0 0", cs_count - cs0, obs_q.size() - nobs, busy);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_timeout();
        test_edit_abort();
        test_group3();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
